// File: rtl/data_mem_responder.sv
// Load/store target for the core's data port: 128-word byte-addressable array with
// sub-word access, sign/zero extension, programmable wait states and request rejection.
module data_mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              err
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_r, next_state_s;
    logic [3:0]          cnt_r;
    logic [ADDR_W-1:0]   req_addr_r;
    logic [2:0]          req_funct3_r;
    logic                req_load_r;
    logic [DATA_W-1:0]   mem_r [0:DEPTH-1];

    logic                misaligned_s, legal_s;
    logic                accept_s, reject_s, load_ok_s, store_ok_s;
    logic [DATA_W-1:0]   rd_word_s, resp_word_s;
    logic [DATA_W-1:0]   rd_data_next_s;
    logic                rd_valid_next_s, busy_next_s, err_next_s;

    // Select the addressed byte/half of a word and extend it to full width.
    function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] word,
                                                       input logic [1:0] lane,
                                                       input logic [2:0] f3);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b010:  res = word;
            3'b100:  res = {24'd0, b};
            3'b101:  res = {16'd0, h};
            default: res = {DATA_W{1'b0}};
        endcase
        return res;
    endfunction

    // Merge right-aligned store data into the old word; other byte lanes are preserved.
    function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] old,
                                                      input logic [DATA_W-1:0] data,
                                                      input logic [1:0] lane,
                                                      input logic [2:0] f3);
        logic [DATA_W-1:0] res;
        res = old;
        case (f3)
            3'b000:  res[{lane, 3'b000} +: 8]    = data[7:0];
            3'b001:  res[{lane[1], 4'b0000} +: 16] = data[15:0];
            3'b010:  res = data;
            default: res = old;
        endcase
        return res;
    endfunction

    // Request decode: alignment and funct3 legality for the presented access.
    always_comb begin
        misaligned_s = 1'b0;
        legal_s      = 1'b0;
        if (funct3[1:0] == 2'b01) begin
            misaligned_s = addr[0];
        end else if (funct3[1:0] == 2'b10) begin
            misaligned_s = (addr[1:0] != 2'b00);
        end else begin
            misaligned_s = 1'b0;
        end
        if (wr) begin
            case (funct3)
                3'b000, 3'b001, 3'b010: legal_s = 1'b1;
                default:                legal_s = 1'b0;
            endcase
        end else begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_s = 1'b1;
                default:                                legal_s = 1'b0;
            endcase
        end
    end

    assign accept_s    = (state_r == ST_IDLE) && (rd || wr);
    assign reject_s    = accept_s && ((rd && wr) || misaligned_s || !legal_s);
    assign load_ok_s   = accept_s && rd && !reject_s;
    assign store_ok_s  = accept_s && wr && !reject_s;
    assign rd_word_s   = mem_r[addr[ADDR_W-1:2]];
    assign resp_word_s = mem_r[req_addr_r[ADDR_W-1:2]];

    // Storage array: written at the accept edge, never cleared by reset.
    always_ff @(posedge clk) begin
        if (store_ok_s) begin
            mem_r[addr[ADDR_W-1:2]] <= store_merge(rd_word_s, wr_data, addr[1:0], funct3);
        end
    end

    // FSM state register plus wait counter and latched request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            req_addr_r   <= {ADDR_W{1'b0}};
            req_funct3_r <= 3'b000;
            req_load_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (load_ok_s || store_ok_s) begin
                cnt_r        <= 4'(WAIT_CYCLES);
                req_addr_r   <= addr;
                req_funct3_r <= funct3;
                req_load_r   <= load_ok_s;
            end else if (state_r == ST_WAIT) begin
                cnt_r <= cnt_r - 4'd1;
            end
        end
    end

    // Next-state logic; rejected requests never leave IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if ((load_ok_s || store_ok_s) && (WAIT_CYCLES > 0)) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd1) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode; a rejected load still answers with zero so the core cannot hang.
    always_comb begin
        rd_data_next_s  = rd_data;
        rd_valid_next_s = 1'b0;
        err_next_s      = 1'b0;
        busy_next_s     = (next_state_s != ST_IDLE);
        if (reject_s && rd) begin
            rd_valid_next_s = 1'b1;
            rd_data_next_s  = {DATA_W{1'b0}};
            err_next_s      = 1'b1;
        end else if (reject_s) begin
            err_next_s = 1'b1;
        end else if (load_ok_s && (WAIT_CYCLES == 0)) begin
            rd_valid_next_s = 1'b1;
            rd_data_next_s  = load_extract(rd_word_s, addr[1:0], funct3);
        end else if ((state_r == ST_RESP) && req_load_r) begin
            rd_valid_next_s = 1'b1;
            rd_data_next_s  = load_extract(resp_word_s, req_addr_r[1:0], req_funct3_r);
        end else begin
            rd_valid_next_s = 1'b0;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data  <= {DATA_W{1'b0}};
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            rd_data  <= rd_data_next_s;
            rd_valid <= rd_valid_next_s;
            busy     <= busy_next_s;
            err      <= err_next_s;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with no wait states, one with three.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr0, rd0, wr3, rd3;
    logic [8:0]  addr0, addr3;
    logic [2:0]  f3_0, f3_3;
    logic [31:0] wdata0, wdata3;
    logic [31:0] rdata0, rdata3;
    logic        rvalid0, rvalid3, busy0, busy3, err0, err3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .wr(wr0), .rd(rd0), .addr(addr0), .funct3(f3_0),
        .wr_data(wdata0), .rd_data(rdata0), .rd_valid(rvalid0), .busy(busy0), .err(err0));

    data_mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .wr(wr3), .rd(rd3), .addr(addr3), .funct3(f3_3),
        .wr_data(wdata3), .rd_data(rdata3), .rd_valid(rvalid3), .busy(busy3), .err(err3));

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [8:0]  addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
        logic        exp_valid;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic w, input logic r, input logic [8:0] a,
                                input logic [2:0] f, input logic [31:0] d,
                                input logic ev, input logic ee, input logic [31:0] ed);
        vec_t v;
        v.wr = w; v.rd = r; v.addr = a; v.f3 = f; v.wdata = d;
        v.exp_valid = ev; v.exp_err = ee; v.exp_data = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic w, input logic r, input logic [8:0] a,
                         input logic [2:0] f, input logic [31:0] data);
        if (d == 0) begin
            wr0 = w; rd0 = r; addr0 = a; f3_0 = f; wdata0 = data;
        end else begin
            wr3 = w; rd3 = r; addr3 = a; f3_3 = f; wdata3 = data;
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 9'h000, 3'b000, 32'h0);
        drive(3, 1'b0, 1'b0, 9'h000, 3'b000, 32'h0);
        step();
        step();
        check("reset rd_data0", rdata0, 32'h0);
        check("reset rd_valid0", {31'd0, rvalid0}, 32'h0);
        check("reset busy0", {31'd0, busy0}, 32'h0);
        check("reset err0", {31'd0, err0}, 32'h0);
        check("reset rd_data3", rdata3, 32'h0);
        check("reset busy3", {31'd0, busy3}, 32'h0);
        reset = 1'b1;
        step();

        // Zero-wait instance: stores, loads, extension and rejection.
        vecs.push_back(mk(1'b1, 1'b0, 9'h010, 3'b010, 32'hDEADBEEF, 1'b0, 1'b0, 32'h00000000));
        vecs.push_back(mk(1'b0, 1'b1, 9'h010, 3'b010, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF));
        vecs.push_back(mk(1'b1, 1'b0, 9'h010, 3'b010, 32'h11223344, 1'b0, 1'b0, 32'hDEADBEEF));
        vecs.push_back(mk(1'b1, 1'b0, 9'h013, 3'b000, 32'h00000080, 1'b0, 1'b0, 32'hDEADBEEF));
        vecs.push_back(mk(1'b0, 1'b1, 9'h013, 3'b000, 32'h0,        1'b1, 1'b0, 32'hFFFFFF80));
        vecs.push_back(mk(1'b0, 1'b1, 9'h013, 3'b100, 32'h0,        1'b1, 1'b0, 32'h00000080));
        vecs.push_back(mk(1'b0, 1'b1, 9'h012, 3'b001, 32'h0,        1'b1, 1'b0, 32'hFFFF8022));
        vecs.push_back(mk(1'b0, 1'b1, 9'h010, 3'b101, 32'h0,        1'b1, 1'b0, 32'h00003344));
        vecs.push_back(mk(1'b0, 1'b1, 9'h012, 3'b101, 32'h0,        1'b1, 1'b0, 32'h00008022));
        vecs.push_back(mk(1'b1, 1'b0, 9'h011, 3'b001, 32'h0000BEEF, 1'b0, 1'b1, 32'h00008022));
        vecs.push_back(mk(1'b0, 1'b1, 9'h010, 3'b010, 32'h0,        1'b1, 1'b0, 32'h80223344));
        vecs.push_back(mk(1'b1, 1'b1, 9'h010, 3'b010, 32'h0,        1'b1, 1'b1, 32'h00000000));
        vecs.push_back(mk(1'b0, 1'b1, 9'h010, 3'b010, 32'h0,        1'b1, 1'b0, 32'h80223344));
        vecs.push_back(mk(1'b0, 1'b1, 9'h010, 3'b011, 32'h0,        1'b1, 1'b1, 32'h00000000));
        vecs.push_back(mk(1'b0, 1'b1, 9'h010, 3'b010, 32'h0,        1'b1, 1'b0, 32'h80223344));
        vecs.push_back(mk(1'b0, 1'b1, 9'h012, 3'b010, 32'h0,        1'b1, 1'b1, 32'h00000000));
        vecs.push_back(mk(1'b1, 1'b0, 9'h011, 3'b000, 32'h000000AB, 1'b0, 1'b0, 32'h00000000));
        vecs.push_back(mk(1'b0, 1'b1, 9'h011, 3'b000, 32'h0,        1'b1, 1'b0, 32'hFFFFFFAB));
        vecs.push_back(mk(1'b0, 1'b1, 9'h011, 3'b100, 32'h0,        1'b1, 1'b0, 32'h000000AB));
        vecs.push_back(mk(1'b1, 1'b0, 9'h014, 3'b010, 32'h12345678, 1'b0, 1'b0, 32'h000000AB));
        vecs.push_back(mk(1'b1, 1'b0, 9'h014, 3'b011, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h000000AB));
        vecs.push_back(mk(1'b1, 1'b0, 9'h014, 3'b100, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h000000AB));
        vecs.push_back(mk(1'b0, 1'b1, 9'h013, 3'b001, 32'h0,        1'b1, 1'b1, 32'h00000000));
        vecs.push_back(mk(1'b0, 1'b1, 9'h014, 3'b010, 32'h0,        1'b1, 1'b0, 32'h12345678));
        vecs.push_back(mk(1'b0, 1'b0, 9'h014, 3'b010, 32'h0,        1'b0, 1'b0, 32'h12345678));
        vecs.push_back(mk(1'b0, 1'b1, 9'h010, 3'b010, 32'h0,        1'b1, 1'b0, 32'h8022AB44));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(0, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].f3, vecs[i].wdata);
            step();
            check($sformatf("vec%0d rd_valid", i), {31'd0, rvalid0}, {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d err", i), {31'd0, err0}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d rd_data", i), rdata0, vecs[i].exp_data);
            check($sformatf("vec%0d busy", i), {31'd0, busy0}, 32'h0);
        end
        drive(0, 1'b0, 1'b0, 9'h000, 3'b000, 32'h0);

        // Three-wait instance: store timing, then a load with an ignored request while busy.
        drive(3, 1'b1, 1'b0, 9'h020, 3'b010, 32'hCAFEF00D);
        step();
        drive(3, 1'b0, 1'b0, 9'h000, 3'b000, 32'h0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("sw busy c%0d", k), {31'd0, busy3}, 32'h1);
            step();
        end
        check("sw busy end", {31'd0, busy3}, 32'h0);
        check("sw no rd_valid", {31'd0, rvalid3}, 32'h0);

        drive(3, 1'b0, 1'b1, 9'h020, 3'b010, 32'h0);
        step();
        for (int k = 0; k < 4; k++) begin
            if (k < 2) drive(3, 1'b1, 1'b0, 9'h020, 3'b010, 32'h0BADBEEF);
            else       drive(3, 1'b0, 1'b0, 9'h000, 3'b000, 32'h0);
            check($sformatf("lw busy c%0d", k), {31'd0, busy3}, 32'h1);
            check($sformatf("lw rd_valid early c%0d", k), {31'd0, rvalid3}, 32'h0);
            step();
        end
        check("lw busy dropped", {31'd0, busy3}, 32'h0);
        check("lw rd_valid", {31'd0, rvalid3}, 32'h1);
        check("lw rd_data", rdata3, 32'hCAFEF00D);
        step();
        check("lw rd_valid pulse", {31'd0, rvalid3}, 32'h0);

        drive(3, 1'b0, 1'b1, 9'h020, 3'b010, 32'h0);
        step();
        drive(3, 1'b0, 1'b0, 9'h000, 3'b000, 32'h0);
        for (int k = 0; k < 4; k++) step();
        check("ignored store rd_valid", {31'd0, rvalid3}, 32'h1);
        check("ignored store data", rdata3, 32'hCAFEF00D);

        // Reset during the second wait cycle of a pending load.
        drive(3, 1'b1, 1'b0, 9'h024, 3'b010, 32'h5A5A1234);
        step();
        drive(3, 1'b0, 1'b0, 9'h000, 3'b000, 32'h0);
        for (int k = 0; k < 4; k++) step();
        drive(3, 1'b0, 1'b1, 9'h024, 3'b010, 32'h0);
        step();
        drive(3, 1'b0, 1'b0, 9'h000, 3'b000, 32'h0);
        step();
        check("pre-reset busy", {31'd0, busy3}, 32'h1);
        reset = 1'b0;
        #1;
        check("mid-wait reset rd_data", rdata3, 32'h0);
        check("mid-wait reset busy", {31'd0, busy3}, 32'h0);
        check("mid-wait reset rd_valid", {31'd0, rvalid3}, 32'h0);
        step();
        step();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("dropped load rd_valid c%0d", k), {31'd0, rvalid3}, 32'h0);
        end
        drive(3, 1'b0, 1'b1, 9'h024, 3'b010, 32'h0);
        step();
        drive(3, 1'b0, 1'b0, 9'h000, 3'b000, 32'h0);
        for (int k = 0; k < 4; k++) step();
        check("post-reset rd_valid", {31'd0, rvalid3}, 32'h1);
        check("post-reset rd_data", rdata3, 32'h5A5A1234);

        // Fill every word, read back in reverse order.
        for (int i = 0; i < 128; i++) begin
            drive(0, 1'b1, 1'b0, 9'(i * 4), 3'b010, 32'(i) ^ 32'hA5A5A5A5);
            step();
        end
        for (int i = 127; i >= 0; i--) begin
            drive(0, 1'b0, 1'b1, 9'(i * 4), 3'b010, 32'h0);
            step();
            check($sformatf("fill w%0d rd_valid", i), {31'd0, rvalid0}, 32'h1);
            check($sformatf("fill w%0d rd_data", i), rdata0, 32'(i) ^ 32'hA5A5A5A5);
        end
        drive(0, 1'b0, 1'b0, 9'h000, 3'b000, 32'h0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
